bit_beeper: RTL and testbench

- Downstream consumer of the Avalon single-bit output port: its trigger input is driven directly by that port's output bit.
- A rising edge on the trigger starts a buzzer burst. A burst is a square-wave tone gated by ON/OFF cadence windows, repeated for a programmed count.
- Timing and control registers sit on an 8-bit Avalon-MM slave so the watch firmware can set tone and cadence.
- Drives the piezo pin and an optional completion interrupt.

---
 rtl/bit_beeper.sv | 189 ++++++++++++++++++
 tb/tb_bit_beeper.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_beeper.sv
// bit_beeper: trigger-started piezo burst generator (tone gated by ON/OFF cadence) with an 8-bit Avalon-MM register slave.
module bit_beeper #(
    parameter int PRESCALE = 50,
    parameter int MS_DIV   = 1000
) (
    input  logic       csi_clk,
    input  logic       csi_reset_n,
    input  logic [3:0] avs_s1_address,
    input  logic       avs_s1_read,
    output logic [7:0] avs_s1_readdata,
    input  logic       avs_s1_write,
    input  logic [7:0] avs_s1_writedata,
    input  logic       coe_trigger,
    output logic       coe_buzzer,
    output logic       ins_irq
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int MW = MS_DIV > 1 ? $clog2(MS_DIV) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_nxt;
    logic [3:0]    r_ctrl;
    logic [7:0]    r_tone_div;
    logic [7:0]    r_on;
    logic [7:0]    r_off;
    logic [7:0]    r_burst;
    logic [7:0]    r_burst_l;
    logic [7:0]    r_cnt;
    logic [7:0]    r_len;
    logic [7:0]    r_ms;
    logic [7:0]    r_tone;
    logic [7:0]    r_rdata;
    logic [PW-1:0] r_pre;
    logic [MW-1:0] r_us;
    logic          r_done;
    logic          r_trig;
    logic          r_buzz;
    logic          r_irq;

    logic [3:0] w_ctrl_nxt;
    logic [7:0] w_tdiv;
    logic [7:0] w_cnt_inc;
    logic [7:0] w_rdata;
    logic       w_wr_ctrl;
    logic       w_wr_stat;
    logic       w_start;
    logic       w_abort;
    logic       w_us_tick;
    logic       w_ms_tick;
    logic       w_end;
    logic       w_last;
    logic       w_toggle;
    logic       w_on_end;
    logic       w_done_set;
    logic       w_active;
    logic       w_enter_on;
    logic       w_enter_off;

    assign w_wr_ctrl  = avs_s1_write && avs_s1_address == 4'd0;
    assign w_wr_stat  = avs_s1_write && avs_s1_address == 4'd5;
    // START is a pulse, so it is never stored; EN/HOLD decisions see the value being written this cycle
    assign w_ctrl_nxt = w_wr_ctrl ? {avs_s1_writedata[3], 1'b0, avs_s1_writedata[1:0]} : r_ctrl;
    assign w_start    = w_ctrl_nxt[0] && r_state == S_IDLE &&
                        ((w_wr_ctrl && avs_s1_writedata[2]) || (coe_trigger && !r_trig));
    assign w_abort    = !w_ctrl_nxt[0] || (w_ctrl_nxt[1] && !coe_trigger);

    assign w_us_tick  = r_pre == PW'(PRESCALE - 1);
    assign w_ms_tick  = w_us_tick && r_us == MW'(MS_DIV - 1);
    assign w_end      = w_ms_tick && r_ms == r_len - 8'd1;
    assign w_tdiv     = r_tone_div == 8'd0 ? 8'd1 : r_tone_div;
    assign w_toggle   = w_us_tick && r_tone >= w_tdiv - 8'd1;
    assign w_cnt_inc  = r_cnt + {7'd0, r_cnt != 8'hFF};
    assign w_last     = r_burst_l != 8'd0 && w_cnt_inc == r_burst_l;
    assign w_on_end   = r_state == S_ON && !w_abort && w_end;
    assign w_done_set = w_on_end && w_last;

    assign w_rdata = avs_s1_address == 4'd0 ? {4'd0, r_ctrl} :
                     avs_s1_address == 4'd1 ? r_tone_div :
                     avs_s1_address == 4'd2 ? r_on :
                     avs_s1_address == 4'd3 ? r_off :
                     avs_s1_address == 4'd4 ? r_burst :
                     avs_s1_address == 4'd5 ? {6'd0, r_done, w_active} : 8'd0;

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state == S_IDLE ? (w_start ? S_ON : S_IDLE) :
                w_abort           ? S_IDLE :
                !w_end            ? r_state :
                r_state == S_OFF  ? S_ON :
                w_last            ? S_IDLE :
                r_off == 8'd0     ? S_ON : S_OFF;
    end

    always_comb begin
        w_active    = r_state != S_IDLE;
        w_enter_on  = w_nxt == S_ON && (r_state != S_ON || w_end);
        w_enter_off = w_nxt == S_OFF && r_state != S_OFF;
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            r_ctrl     <= 4'h0;
            r_tone_div <= 8'hFA;
            r_on       <= 8'h64;
            r_off      <= 8'h64;
            r_burst    <= 8'h03;
            r_done     <= 1'b0;
            r_trig     <= 1'b0;
            r_irq      <= 1'b0;
            r_rdata    <= 8'h00;
        end else begin
            r_trig <= coe_trigger;
            r_irq  <= r_done && r_ctrl[3];
            r_ctrl <= w_ctrl_nxt;
            if (avs_s1_write && avs_s1_address == 4'd1)
                r_tone_div <= avs_s1_writedata;
            if (avs_s1_write && avs_s1_address == 4'd2)
                r_on <= avs_s1_writedata;
            if (avs_s1_write && avs_s1_address == 4'd3)
                r_off <= avs_s1_writedata;
            if (avs_s1_write && avs_s1_address == 4'd4)
                r_burst <= avs_s1_writedata;
            r_done <= w_done_set ? 1'b1 :
                      (w_start || (w_wr_stat && avs_s1_writedata[1])) ? 1'b0 : r_done;
            if (avs_s1_read && !avs_s1_write)
                r_rdata <= w_rdata;
        end
    end

    // Cadence and tone datapath; every state entry restarts the window from a clean count
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            r_pre     <= '0;
            r_us      <= '0;
            r_ms      <= 8'd0;
            r_tone    <= 8'd0;
            r_len     <= 8'd0;
            r_burst_l <= 8'd0;
            r_buzz    <= 1'b0;
        end else if (w_enter_on || w_enter_off) begin
            r_pre  <= '0;
            r_us   <= '0;
            r_ms   <= 8'd0;
            r_tone <= 8'd0;
            r_len  <= w_enter_on ? (r_on == 8'd0 ? 8'd1 : r_on) : r_off;
            r_buzz <= w_enter_on;
            if (w_enter_on)
                r_burst_l <= r_burst;
        end else if (w_nxt == S_IDLE) begin
            r_pre  <= '0;
            r_us   <= '0;
            r_ms   <= 8'd0;
            r_tone <= 8'd0;
            r_buzz <= 1'b0;
        end else begin
            r_pre <= w_us_tick ? '0 : r_pre + 1'b1;
            if (w_us_tick)
                r_us <= w_ms_tick ? '0 : r_us + 1'b1;
            if (w_ms_tick)
                r_ms <= r_ms + 8'd1;
            if (w_us_tick)
                r_tone <= w_toggle ? 8'd0 : r_tone + 8'd1;
            if (r_state == S_ON && w_toggle)
                r_buzz <= !r_buzz;
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n)
            r_cnt <= 8'd0;
        else if (w_start)
            r_cnt <= 8'd0;
        else if (w_on_end)
            r_cnt <= w_cnt_inc;
    end

    assign avs_s1_readdata = r_rdata;
    assign coe_buzzer      = r_buzz;
    assign ins_irq         = r_irq;
endmodule

// File: tb/tb_bit_beeper.sv
// tb_bit_beeper: directed-vector bench for bit_beeper with PRESCALE=2, MS_DIV=4 (1 ms = 8 clocks).
module tb_bit_beeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] addr;
    logic       rd_en;
    logic [7:0] rdata;
    logic       wr_en;
    logic [7:0] wdata;
    logic       trig;
    logic       buzzer;
    logic       irq;
    int         n_run = 0;
    int         n_fail = 0;
    logic [7:0] v;
    logic [63:0] got;
    logic [63:0] exp;

    bit_beeper #(.PRESCALE(2), .MS_DIV(4)) dut (
        .csi_clk(clk),
        .csi_reset_n(rst_n),
        .avs_s1_address(addr),
        .avs_s1_read(rd_en),
        .avs_s1_readdata(rdata),
        .avs_s1_write(wr_en),
        .avs_s1_writedata(wdata),
        .coe_trigger(trig),
        .coe_buzzer(buzzer),
        .ins_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_run++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d     = rdata;
    endtask

    function automatic logic tone(input int k);
        return ((k >> 1) & 1) == 0;
    endfunction

    task automatic check_defaults(input string tag);
        logic [3:0] a_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
        logic [7:0] e_tab [7] = '{8'h00, 8'hFA, 8'h64, 8'h64, 8'h03, 8'h00, 8'h00};
        logic [7:0] d;
        for (int i = 0; i < 7; i++) begin
            rd(a_tab[i], d);
            chk($sformatf("%s_reg%0d", tag, a_tab[i]), {56'd0, d}, {56'd0, e_tab[i]});
        end
    endtask

    initial begin
        rst_n = 1'b0; addr = 4'd0; rd_en = 1'b0; wr_en = 1'b0; wdata = 8'd0; trig = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_buzzer", {63'd0, buzzer}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        check_defaults("rst");

        addr = 4'd1; wdata = 8'h05; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wr_rd_hold", {56'd0, rdata}, 64'h00);
        rd(4'd1, v);
        chk("wr_rd_written", {56'd0, v}, 64'h05);

        // basic burst: ON 16 clk, OFF 8 clk, ON 16 clk
        wr(4'd1, 8'd1); wr(4'd2, 8'd2); wr(4'd3, 8'd1); wr(4'd4, 8'd2); wr(4'd0, 8'h09);
        trig = 1'b1;
        tick();
        got = '0; exp = '0;
        for (int k = 0; k < 48; k++) begin
            got[k] = buzzer;
            exp[k] = k < 16 ? tone(k) : k < 24 ? 1'b0 : k < 40 ? tone(k - 24) : 1'b0;
            if (k == 40) chk("basic_irq_lag", {63'd0, irq}, 64'd0);
            if (k == 41) chk("basic_irq_rise", {63'd0, irq}, 64'd1);
            tick();
        end
        chk("basic_wave", got, exp);
        rd(4'd5, v);
        chk("basic_status", {56'd0, v}, 64'h02);
        trig = 1'b0;
        tick();

        // OFF_TIME=0: back-to-back windows
        wr(4'd2, 8'd1); wr(4'd3, 8'd0); wr(4'd4, 8'd3);
        wr(4'd0, 8'h0D);
        got = '0; exp = '0;
        for (int k = 0; k < 32; k++) begin
            got[k] = buzzer;
            exp[k] = k < 24 ? tone(k % 8) : 1'b0;
            if (k == 2) chk("b2b_irq_cleared_by_start", {63'd0, irq}, 64'd0);
            if (k == 25) chk("b2b_irq", {63'd0, irq}, 64'd1);
            tick();
        end
        chk("b2b_wave", got, exp);
        rd(4'd5, v);
        chk("b2b_status", {56'd0, v}, 64'h02);
        wr(4'd5, 8'h02);
        tick();
        chk("w1c_irq", {63'd0, irq}, 64'd0);
        rd(4'd5, v);
        chk("w1c_status", {56'd0, v}, 64'h00);

        // abort via HOLD with trigger dropped in second ON window
        wr(4'd3, 8'd1); wr(4'd4, 8'd0); wr(4'd0, 8'h0B);
        trig = 1'b1;
        tick();
        for (int k = 0; k < 19; k++) begin
            if (k == 17) chk("hold_running", {63'd0, buzzer}, 64'd1);
            tick();
        end
        trig = 1'b0;
        tick();
        chk("hold_abort_buzzer", {63'd0, buzzer}, 64'd0);
        rd(4'd5, v);
        chk("hold_abort_status", {56'd0, v}, 64'h00);

        // abort via EN cleared
        wr(4'd0, 8'h09);
        trig = 1'b1;
        tick();
        for (int k = 0; k < 19; k++) begin
            if (k == 17) chk("en_running", {63'd0, buzzer}, 64'd1);
            tick();
        end
        wr(4'd0, 8'h08);
        chk("en_abort_buzzer", {63'd0, buzzer}, 64'd0);
        rd(4'd5, v);
        chk("en_abort_status", {56'd0, v}, 64'h00);
        rd(4'd0, v);
        chk("en_ctrl_read", {56'd0, v}, 64'h08);
        trig = 1'b0;
        tick();

        // trigger edge with EN=0 is ignored
        trig = 1'b1;
        tick(); tick();
        chk("en0_buzzer", {63'd0, buzzer}, 64'd0);
        rd(4'd5, v);
        chk("en0_status", {56'd0, v}, 64'h00);
        trig = 1'b0;
        tick();

        // mid-burst trigger re-pulse and START write do not disturb cadence
        wr(4'd4, 8'd2); wr(4'd0, 8'h09);
        trig = 1'b1;
        tick();
        got = '0; exp = '0;
        for (int k = 0; k < 32; k++) begin
            got[k] = buzzer;
            exp[k] = k < 8 ? tone(k) : k < 16 ? 1'b0 : k < 24 ? tone(k - 16) : 1'b0;
            if (k == 4) trig = 1'b0;
            if (k == 6) trig = 1'b1;
            if (k == 10) begin addr = 4'd0; wdata = 8'h0D; wr_en = 1'b1; end
            if (k == 11) wr_en = 1'b0;
            tick();
        end
        chk("restart_ignored_wave", got, exp);
        trig = 1'b0;
        tick();

        // START and trigger edge together give one burst
        wr(4'd4, 8'd1);
        trig = 1'b1; addr = 4'd0; wdata = 8'h0D; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        got = '0; exp = '0;
        for (int k = 0; k < 24; k++) begin
            got[k] = buzzer;
            exp[k] = k < 8 ? tone(k) : 1'b0;
            tick();
        end
        chk("dual_start_wave", got, exp);
        rd(4'd5, v);
        chk("dual_start_status", {56'd0, v}, 64'h02);
        trig = 1'b0;
        tick();

        // asynchronous reset mid-burst, trigger held high across release
        wr(4'd4, 8'd0);
        trig = 1'b1;
        tick();
        repeat (4) tick();
        chk("rstmid_running", {63'd0, buzzer}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rstmid_async_buzzer", {63'd0, buzzer}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        chk("rstmid_no_restart", {63'd0, buzzer}, 64'd0);
        check_defaults("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
